// File: rtl/am_envelope_demod.sv
`default_nettype none
//----------------------------------------------------------------------------
// am_envelope_demod : CORDIC-magnitude AM envelope detector with leaky DC block
// Rev 1.0
//----------------------------------------------------------------------------
module am_envelope_demod #(
   parameter int ITER     = 12,
   parameter int DC_SHIFT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_tick,
   input  logic [15:0] i_in,
   input  logic [15:0] q_in,
   output logic        ready,
   output logic [15:0] mag_out,
   output logic [15:0] audio_out,
   output logic        out_tick,
   output logic        overrun
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ROT  = 2'd1,
      S_GAIN = 2'd2,
      S_DCB  = 2'd3
   } state_t;

   localparam logic [3:0]         K_LAST = 4'(ITER - 1);
   localparam logic signed [16:0] C_GAIN = 17'sd39797;

   state_t             state_q, state_d;
   logic signed [17:0] x_q, x_d, y_q, y_d;
   logic [3:0]         k_q, k_d;
   logic [15:0]        m_q, m_d, m_prev_q, m_prev_d;
   logic signed [23:0] yacc_q, yacc_d;
   logic [15:0]        mag_out_q, mag_out_d, audio_out_q, audio_out_d;
   logic               out_tick_q, out_tick_d, overrun_q, overrun_d;

   logic signed [17:0] w_i_ext, w_q_ext, w_x_sh, w_y_sh;
   logic signed [34:0] w_prod, w_prod_sh;
   logic [15:0]        w_m_gain, w_audio_sat;
   logic signed [23:0] w_d, w_yacc_new;

   // Widen before negating so that -32768 maps to +32768.
   assign w_i_ext = {{2{i_in[15]}}, i_in};
   assign w_q_ext = {{2{q_in[15]}}, q_in};
   assign w_x_sh  = x_q >>> k_q;
   assign w_y_sh  = y_q >>> k_q;

   assign w_prod    = 35'(x_q) * 35'(C_GAIN);
   assign w_prod_sh = w_prod >>> 16;
   assign w_m_gain  = (w_prod_sh < 35'sd0)     ? 16'd0 :
                      (w_prod_sh > 35'sd65535) ? 16'hFFFF : w_prod_sh[15:0];

   assign w_d         = {8'd0, m_q} - {8'd0, m_prev_q};
   assign w_yacc_new  = yacc_q + w_d - (yacc_q >>> DC_SHIFT);
   assign w_audio_sat = (w_yacc_new > 24'sd32767)  ? 16'h7FFF :
                        (w_yacc_new < -24'sd32768) ? 16'h8000 : w_yacc_new[15:0];

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      k_d         = k_q;
      m_d         = m_q;
      m_prev_d    = m_prev_q;
      yacc_d      = yacc_q;
      mag_out_d   = mag_out_q;
      audio_out_d = audio_out_q;
      out_tick_d  = 1'b0;
      overrun_d   = overrun_q | (in_tick & (state_q != S_IDLE));
      case (state_q)
         S_IDLE: begin
            if (in_tick) begin
               if (i_in[15]) begin
                  x_d = -w_i_ext;
                  y_d = -w_q_ext;
               end else begin
                  x_d = w_i_ext;
                  y_d = w_q_ext;
               end
               k_d     = 4'd0;
               state_d = S_ROT;
            end
         end
         S_ROT: begin
            if (y_q[17]) begin
               x_d = x_q - w_y_sh;
               y_d = y_q + w_x_sh;
            end else begin
               x_d = x_q + w_y_sh;
               y_d = y_q - w_x_sh;
            end
            k_d = k_q + 4'd1;
            if (k_q == K_LAST) state_d = S_GAIN;
         end
         S_GAIN: begin
            m_d     = w_m_gain;
            state_d = S_DCB;
         end
         S_DCB: begin
            m_prev_d    = m_q;
            yacc_d      = w_yacc_new;
            mag_out_d   = m_q;
            audio_out_d = w_audio_sat;
            out_tick_d  = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         k_q         <= '0;
         m_q         <= '0;
         m_prev_q    <= '0;
         yacc_q      <= '0;
         mag_out_q   <= '0;
         audio_out_q <= '0;
         out_tick_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         k_q         <= k_d;
         m_q         <= m_d;
         m_prev_q    <= m_prev_d;
         yacc_q      <= yacc_d;
         mag_out_q   <= mag_out_d;
         audio_out_q <= audio_out_d;
         out_tick_q  <= out_tick_d;
         overrun_q   <= overrun_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign mag_out   = mag_out_q;
   assign audio_out = audio_out_q;
   assign out_tick  = out_tick_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_am_envelope_demod.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_am_envelope_demod : directed vector bench for am_envelope_demod
// Rev 1.0
//----------------------------------------------------------------------------
module tb_am_envelope_demod;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_tick = 1'b0;
   logic [15:0] i_in = '0;
   logic [15:0] q_in = '0;
   logic        ready;
   logic [15:0] mag_out;
   logic [15:0] audio_out;
   logic        out_tick;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int i;
      int q;
      int mag_lo;
      int mag_hi;
      int aud;
   } vec_t;

   vec_t vecs[8];

   am_envelope_demod #(.ITER(12), .DC_SHIFT(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_tick   (in_tick),
      .i_in      (i_in),
      .q_in      (q_in),
      .ready     (ready),
      .mag_out   (mag_out),
      .audio_out (audio_out),
      .out_tick  (out_tick),
      .overrun   (overrun)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic do_reset();
      RST     = 1'b1;
      in_tick = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Present one pair at a negedge; returns #1 after the sampling edge.
   task automatic pulse(input int i, input int q);
      @(negedge CLK);
      i_in    = 16'(i);
      q_in    = 16'(q);
      in_tick = 1'b1;
      @(posedge CLK);
      #1;
      in_tick = 1'b0;
   endtask

   // Waits (bounded) for out_tick; lat counts edges after the current one.
   task automatic collect(output int lat, output int rdy_low, output int mag, output int aud);
      lat     = 0;
      rdy_low = ready ? 0 : 1;
      mag     = -1;
      aud     = -99999;
      for (int c = 0; c < 40; c++) begin
         @(posedge CLK);
         #1;
         lat++;
         if (out_tick) begin
            mag = int'(mag_out);
            aud = int'($signed(audio_out));
            break;
         end
         if (!ready) rdy_low++;
      end
   endtask

   task automatic count_ticks(input int n, output int cnt);
      cnt = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge CLK);
         #1;
         if (out_tick) cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rlow, mag, aud, cnt;

      vecs[0] = '{1000,       0,   998,  1001,  1001};
      vecs[1] = '{1000,       0,   998,  1001,   998};
      vecs[2] = '{1000,       0,   998,  1001,   995};
      vecs[3] = '{-3000,   4000,  4996,  5004,  4991};
      vecs[4] = '{0,      -2000,  1996,  2004,  1974};
      vecs[5] = '{-32768, -32768, 46337, 46345, 32767};
      vecs[6] = '{0,          0,     0,     0,  -215};
      vecs[7] = '{0,          0,     0,     0,  -214};

      do_reset();
      check_eq("reset_mag", int'(mag_out), 0);
      check_eq("reset_audio", int'(audio_out), 0);
      check_eq("reset_out_tick", int'(out_tick), 0);
      check_eq("reset_overrun", int'(overrun), 0);
      check_eq("reset_ready", int'(ready), 1);

      for (int v = 0; v < 8; v++) begin
         pulse(vecs[v].i, vecs[v].q);
         collect(lat, rlow, mag, aud);
         check_eq($sformatf("vec%0d_latency", v), lat, 14);
         check_eq($sformatf("vec%0d_ready_low", v), rlow, 14);
         check_rng($sformatf("vec%0d_mag", v), mag, vecs[v].mag_lo, vecs[v].mag_hi);
         check_eq($sformatf("vec%0d_audio", v), aud, vecs[v].aud);
         @(posedge CLK);
         #1;
         check_eq($sformatf("vec%0d_tick_one_cycle", v), int'(out_tick), 0);
         check_eq($sformatf("vec%0d_mag_hold", v), int'(mag_out), mag);
         repeat (4) @(posedge CLK);
      end
      check_eq("no_overrun_normal", int'(overrun), 0);

      // Positive clamp, then a drop that stays unclamped.
      do_reset();
      pulse(0, 0);
      collect(lat, rlow, mag, aud);
      check_eq("sat_zero_audio", aud, 0);
      check_eq("sat_zero_mag", mag, 0);
      pulse(-32768, -32768);
      collect(lat, rlow, mag, aud);
      check_rng("sat_big_mag", mag, 46337, 46345);
      check_eq("sat_pos_audio", aud, 32767);
      pulse(0, 0);
      collect(lat, rlow, mag, aud);
      check_eq("sat_drop_audio", aud, -181);

      // Let the accumulator leak down under a constant large carrier, then drop it.
      do_reset();
      for (int n = 0; n < 401; n++) begin
         pulse(-32768, -32768);
         collect(lat, rlow, mag, aud);
      end
      check_rng("leak_audio_positive", aud, 1, 32766);
      pulse(0, 0);
      collect(lat, rlow, mag, aud);
      check_eq("sat_neg_audio", aud, -32768);
      pulse(0, 0);
      collect(lat, rlow, mag, aud);
      check_eq("sat_neg_audio_hold", aud, -32768);

      // in_tick on the output edge itself is dropped.
      do_reset();
      pulse(1000, 0);
      repeat (13) @(posedge CLK);
      #1;
      i_in    = 16'(-3000);
      q_in    = 16'(4000);
      in_tick = 1'b1;
      @(posedge CLK);
      #1;
      in_tick = 1'b0;
      check_eq("edge_out_tick", int'(out_tick), 1);
      check_eq("edge_audio", int'($signed(audio_out)), 1001);
      check_eq("edge_overrun", int'(overrun), 1);
      count_ticks(30, cnt);
      check_eq("edge_no_extra_tick", cnt, 0);

      // Second in_tick three clocks into a computation.
      do_reset();
      pulse(1000, 0);
      repeat (2) @(posedge CLK);
      pulse(-32768, -32768);
      collect(lat, rlow, mag, aud);
      check_eq("ovr_latency", lat, 11);
      check_rng("ovr_mag", mag, 998, 1001);
      check_eq("ovr_audio", aud, 1001);
      check_eq("ovr_flag", int'(overrun), 1);
      count_ticks(30, cnt);
      check_eq("ovr_single_tick", cnt, 0);
      pulse(1000, 0);
      collect(lat, rlow, mag, aud);
      check_eq("ovr_next_audio", aud, 998);
      check_eq("ovr_sticky", int'(overrun), 1);

      // Asynchronous reset in the middle of rotation.
      pulse(1000, 0);
      repeat (5) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check_eq("midrst_mag", int'(mag_out), 0);
      check_eq("midrst_audio", int'(audio_out), 0);
      check_eq("midrst_out_tick", int'(out_tick), 0);
      check_eq("midrst_overrun", int'(overrun), 0);
      check_eq("midrst_ready", int'(ready), 1);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      count_ticks(20, cnt);
      check_eq("midrst_no_tick", cnt, 0);
      pulse(1000, 0);
      collect(lat, rlow, mag, aud);
      check_eq("midrst_latency", lat, 14);
      check_rng("midrst_mag", mag, 998, 1001);
      check_eq("midrst_audio", aud, 1001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
